// File: rtl/dot_arb_pkg.sv
// Shared types and width constants for the dot-product arbiter slice.
package dot_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_TAG_DEPTH  = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TAG_W      = $clog2(DEF_NUM_REQ);
    localparam int unsigned DEF_CNT_W      = $clog2(DEF_TAG_DEPTH) + 1;

    typedef logic signed [2:0][DEF_DATA_WIDTH-1:0] vec3_t;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dot_tag_fifo.sv
// In-order queue of requester indices for operations in flight in the shared unit.
module dot_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dot_arbiter.sv
// Round-robin sharing of one FIFO-wrapped dot-product unit, with in-order result return.
module dot_arbiter
    import dot_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned TAG_DEPTH  = DEF_TAG_DEPTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int unsigned TAG_W = $clog2(NUM_REQ),
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [NUM_REQ-1:0][2:0][DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ-1:0][2:0][DATA_WIDTH-1:0] req_y,
    input  logic [NUM_REQ-1:0]                     req_empty,
    output logic [NUM_REQ-1:0]                     req_rd_en,
    output logic [2:0][DATA_WIDTH-1:0]             dot_x,
    output logic [2:0][DATA_WIDTH-1:0]             dot_y,
    output logic                                   dot_in_empty,
    input  logic                                   dot_in_rd_en,
    input  logic [DATA_WIDTH-1:0]                  dot_out,
    input  logic                                   dot_out_empty,
    output logic                                   dot_out_rd_en,
    output logic [DATA_WIDTH-1:0]                  res_dout,
    input  logic [NUM_REQ-1:0]                     res_full,
    output logic [NUM_REQ-1:0]                     res_wr_en,
    output logic [CNT_W-1:0]                       outstanding,
    output logic                                   tag_underflow
);

    arb_state_t       state;
    arb_state_t       state_d;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] grant_d;
    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] rr_ptr_d;
    logic [TAG_W-1:0] grant_inc;
    logic [TAG_W-1:0] pick;
    logic             found;
    logic             accept;
    logic [TAG_W-1:0] tag_head;
    logic             tag_full;
    logic             tag_empty;
    logic             ret_ok;

    assign grant_inc = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);
    assign dot_x     = req_x[grant];
    assign dot_y     = req_y[grant];

    // First non-empty requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && !req_empty[TAG_W'(idx)]) begin
                found = 1'b1;
                pick  = TAG_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            grant  <= grant_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    // Issue FSM: grant is registered in IDLE and held in GRANTED until the unit consumes.
    always_comb begin
        state_d      = state;
        grant_d      = grant;
        rr_ptr_d     = rr_ptr;
        accept       = 1'b0;
        dot_in_empty = 1'b1;
        req_rd_en    = '0;
        case (state)
            IDLE: begin
                if (found && !tag_full) begin
                    grant_d = pick;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                dot_in_empty = req_empty[grant];
                if (dot_in_rd_en && !req_empty[grant]) begin
                    accept           = 1'b1;
                    req_rd_en[grant] = 1'b1;
                    rr_ptr_d         = grant_inc;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    dot_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (grant),
        .pop       (ret_ok),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (outstanding)
    );

    // Return router: a full head requester stalls the whole return path to keep order.
    always_comb begin
        ret_ok        = !dot_out_empty && !tag_empty && !res_full[tag_head];
        dot_out_rd_en = ret_ok;
        res_dout      = dot_out;
        res_wr_en     = '0;
        if (ret_ok) begin
            res_wr_en[tag_head] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_underflow <= 1'b0;
        end else if (!dot_out_empty && tag_empty) begin
            tag_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dot_arbiter.sv
// Directed bench for dot_arbiter: bench models requester FIFOs and the shared unit.
module tb_dot_arbiter;
    import dot_arb_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = DEF_CNT_W;

    logic                       clock = 1'b0;
    logic                       reset_n;
    logic [NR-1:0][2:0][DW-1:0] req_x;
    logic [NR-1:0][2:0][DW-1:0] req_y;
    logic [NR-1:0]              req_empty;
    logic [NR-1:0]              req_rd_en;
    logic [2:0][DW-1:0]         dot_x;
    logic [2:0][DW-1:0]         dot_y;
    logic                       dot_in_empty;
    logic                       dot_in_rd_en;
    logic [DW-1:0]              dot_out;
    logic                       dot_out_empty;
    logic                       dot_out_rd_en;
    logic [DW-1:0]              res_dout;
    logic [NR-1:0]              res_full;
    logic [NR-1:0]              res_wr_en;
    logic [CW-1:0]              outstanding;
    logic                       tag_underflow;

    always #5 clock = ~clock;

    dot_arbiter dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_empty     (req_empty),
        .req_rd_en     (req_rd_en),
        .dot_x         (dot_x),
        .dot_y         (dot_y),
        .dot_in_empty  (dot_in_empty),
        .dot_in_rd_en  (dot_in_rd_en),
        .dot_out       (dot_out),
        .dot_out_empty (dot_out_empty),
        .dot_out_rd_en (dot_out_rd_en),
        .res_dout      (res_dout),
        .res_full      (res_full),
        .res_wr_en     (res_wr_en),
        .outstanding   (outstanding),
        .tag_underflow (tag_underflow)
    );

    int n_vec = 0;
    int n_bad = 0;

    int            req_cnt [NR];
    int            req_seq [NR];
    logic [DW-1:0] uq [$];
    int            iss_r [$];
    logic [NR-1:0] del_wr [$];
    logic [DW-1:0] del_d [$];

    bit accept_en;
    bit out_en;
    bit force_uf;

    logic [NR-1:0] cap_rd;
    logic [NR-1:0] cap_wr;
    logic          cap_pop;
    logic          cap_take;
    logic [DW-1:0] cap_dout;
    logic [DW-1:0] cap_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Q10 operands: x=((r+1)*1024, 2048+k*8192, 0), y=(1024,1024,5)
    function automatic vec3_t mk_x(input int r, input int k);
        vec3_t v;
        v[0] = DW'((r + 1) * 1024);
        v[1] = DW'(2048 + k * 8192);
        v[2] = '0;
        return v;
    endfunction

    function automatic vec3_t mk_y();
        vec3_t v;
        v[0] = DW'(1024);
        v[1] = DW'(1024);
        v[2] = DW'(5);
        return v;
    endfunction

    function automatic logic [63:0] exp_res(input int r, input int k);
        return 64'((r + 1) * 1024 + 2048 + k * 8192);
    endfunction

    task automatic drive_inputs();
        for (int r = 0; r < NR; r++) begin
            req_x[r]     = mk_x(r, req_seq[r]);
            req_y[r]     = mk_y();
            req_empty[r] = (req_cnt[r] == 0);
        end
        dot_out_empty = force_uf ? 1'b0 : !(out_en && uq.size() > 0);
        dot_out       = force_uf ? DW'(1234) : ((uq.size() > 0) ? uq[0] : '0);
    endtask

    // One clock: drive at negedge, capture DUT decisions, apply them to the models after posedge.
    task automatic step();
        longint s;
        @(negedge clock);
        drive_inputs();
        #1;
        dot_in_rd_en = accept_en && !dot_in_empty;
        #1;
        cap_rd   = req_rd_en;
        cap_wr   = res_wr_en;
        cap_pop  = dot_out_rd_en;
        cap_dout = res_dout;
        cap_take = dot_in_rd_en && !dot_in_empty;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            s += longint'($signed(dot_x[i])) * longint'($signed(dot_y[i]));
        end
        cap_res = DW'(s >>> 10);
        @(posedge clock);
        #1;
        if (reset_n) begin
            if (cap_take || cap_rd != '0) begin
                check("issue_handshake", {62'd0, cap_take, ($countones(cap_rd) == 1)}, 64'd3);
            end
            for (int r = 0; r < NR; r++) begin
                if (cap_rd[r]) begin
                    iss_r.push_back(r);
                    req_cnt[r]--;
                    req_seq[r]++;
                end
            end
            if (cap_take) uq.push_back(cap_res);
            if (cap_pop) begin
                if (uq.size() > 0) void'(uq.pop_front());
                del_wr.push_back(cap_wr);
                del_d.push_back(cap_dout);
            end
        end
    endtask

    task automatic do_reset(input bit chk);
        reset_n = 1'b0;
        for (int r = 0; r < NR; r++) begin
            req_cnt[r] = 0;
            req_seq[r] = 0;
        end
        uq.delete();
        iss_r.delete();
        del_wr.delete();
        del_d.delete();
        accept_en    = 1'b0;
        out_en       = 1'b0;
        force_uf     = 1'b0;
        res_full     = '0;
        dot_in_rd_en = 1'b0;
        drive_inputs();
        #1;
        if (chk) begin
            check("rst_req_rd_en", 64'(req_rd_en), 64'd0);
            check("rst_res_wr_en", 64'(res_wr_en), 64'd0);
            check("rst_dot_out_rd_en", 64'(dot_out_rd_en), 64'd0);
            check("rst_dot_in_empty", 64'(dot_in_empty), 64'd1);
            check("rst_outstanding", 64'(outstanding), 64'd0);
            check("rst_tag_underflow", 64'(tag_underflow), 64'd0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_iss(input int n, input int bound, input string tag);
        int c = 0;
        while (iss_r.size() < n && c < bound) begin
            step();
            c++;
        end
        check(tag, 64'(iss_r.size()), 64'(n));
    endtask

    task automatic wait_del(input int n, input int bound, input string tag);
        int c = 0;
        while (del_wr.size() < n && c < bound) begin
            step();
            c++;
        end
        check(tag, 64'(del_wr.size()), 64'(n));
    endtask

    initial begin
        bit stall;
        int c;

        // Reset state
        do_reset(1'b1);

        // Single requester: 1024*1024 + 2048*1024 at Q10 = 3072
        req_cnt[0] = 1;
        accept_en  = 1'b1;
        wait_iss(1, 20, "single_issue");
        check("single_grant", 64'(iss_r[0]), 64'd0);
        check("single_outst1", 64'(outstanding), 64'd1);
        check("single_unit_in", 64'(uq[0]), 64'd3072);
        out_en = 1'b1;
        wait_del(1, 20, "single_deliver");
        check("single_wr_en", 64'(del_wr[0]), 64'b0001);
        check("single_dout", 64'(del_d[0]), 64'd3072);
        check("single_outst0", 64'(outstanding), 64'd0);

        // All four requesters, two ops each: round-robin order and in-order return
        do_reset(1'b0);
        for (int r = 0; r < NR; r++) req_cnt[r] = 2;
        accept_en = 1'b1;
        out_en    = 1'b1;
        wait_del(8, 200, "rr_deliver_count");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rr_grant%0d", i), 64'(iss_r[i]), 64'(i % 4));
            check($sformatf("rr_wr%0d", i), 64'(del_wr[i]), 64'(4'b0001 << (i % 4)));
            check($sformatf("rr_dout%0d", i), 64'(del_d[i]), exp_res(i % 4, i / 4));
        end
        check("rr_outst0", 64'(outstanding), 64'd0);

        // Head-of-line blocking on res_full[1]
        do_reset(1'b0);
        req_cnt[0] = 1;
        req_cnt[1] = 1;
        accept_en  = 1'b1;
        wait_iss(2, 20, "hol_issue");
        res_full = 4'b0010;
        out_en   = 1'b1;
        wait_del(1, 20, "hol_first");
        check("hol_first_wr", 64'(del_wr[0]), 64'b0001);
        stall = 1'b0;
        repeat (20) begin
            step();
            if (cap_pop || cap_wr != '0) stall = 1'b1;
        end
        check("hol_stall", 64'(stall), 64'd0);
        check("hol_outst", 64'(outstanding), 64'd1);
        res_full = '0;
        step();
        check("hol_release_wr", 64'(cap_wr), 64'b0010);
        check("hol_release_pop", 64'(cap_pop), 64'd1);
        check("hol_release_dout", 64'(cap_dout), exp_res(1, 0));

        // Tag queue full: eight in flight, ninth waits for the first pop
        do_reset(1'b0);
        req_cnt[0] = 3;
        req_cnt[1] = 2;
        req_cnt[2] = 2;
        req_cnt[3] = 2;
        accept_en  = 1'b1;
        repeat (40) step();
        check("full_outst8", 64'(outstanding), 64'd8);
        check("full_issued8", 64'(iss_r.size()), 64'd8);
        check("full_in_empty", 64'(dot_in_empty), 64'd1);
        out_en = 1'b1;
        wait_del(1, 20, "full_first_pop");
        out_en = 1'b0;
        check("full_outst7", 64'(outstanding), 64'd7);
        wait_iss(9, 10, "full_ninth_issue");
        check("full_ninth_grant", 64'(iss_r[8]), 64'd0);
        check("full_outst8b", 64'(outstanding), 64'd8);

        // Result with no tag: sticky underflow, no pop
        do_reset(1'b0);
        force_uf = 1'b1;
        repeat (3) step();
        check("uf_no_pop", 64'(cap_pop), 64'd0);
        check("uf_no_wr", 64'(cap_wr), 64'd0);
        check("uf_flag", 64'(tag_underflow), 64'd1);
        force_uf = 1'b0;
        repeat (3) step();
        check("uf_sticky", 64'(tag_underflow), 64'd1);
        do_reset(1'b0);
        check("uf_cleared", 64'(tag_underflow), 64'd0);

        // Asynchronous reset while GRANTED with three in flight
        req_cnt[0] = 4;
        accept_en  = 1'b1;
        wait_iss(3, 30, "mid_issue3");
        accept_en = 1'b0;
        c = 0;
        while (dot_in_empty && c < 10) begin
            step();
            c++;
        end
        check("mid_granted", 64'(dot_in_empty), 64'd0);
        check("mid_outst3", 64'(outstanding), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_outst", 64'(outstanding), 64'd0);
        check("mid_rst_in_empty", 64'(dot_in_empty), 64'd1);
        check("mid_rst_rd_en", 64'(req_rd_en), 64'd0);
        check("mid_rst_wr_en", 64'(res_wr_en), 64'd0);
        check("mid_rst_out_rd", 64'(dot_out_rd_en), 64'd0);
        do_reset(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
